// File: rtl/mac_seq.sv
// Purpose: sequences SRAM reads for one MAC row: kernel load, idle gap, activation stream, result drain.
// Latency: first read the cycle after start is accepted; inst_w trails each read by one cycle (SRAM latency).
// Backpressure: hold stalls read issue in LOAD/EXEC; results are counted from valid_last until x_len arrive.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   start                launch request, honoured only when idle
//   hold                 stall for read issue (LOAD/EXEC only)
//   w_base, x_base       first weight / activation address, captured at launch
//   x_len                number of activation vectors, captured at launch
//   valid_last           one pulse per finished result from the last row column
//   mem_cen, mem_addr    SRAM read port (chip enable active-low)
//   inst_w               row instruction: bit1 execute, bit0 kernel load
//   busy, done           status: busy outside IDLE, done pulses for one cycle at completion

module mac_seq #(
   parameter int bw      = 4,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int gap     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               hold,
   input  logic [addr_bw-1:0] w_base,
   input  logic [addr_bw-1:0] x_base,
   input  logic [addr_bw-1:0] x_len,
   input  logic               valid_last,
   output logic               mem_cen,
   output logic [addr_bw-1:0] mem_addr,
   output logic [1:0]         inst_w,
   output logic               busy,
   output logic               done
);

   localparam int kw = (col > 1) ? $clog2(col) : 1;

   if (gap < 1 || gap > 255 || col < 1 || bw < 1) begin : g_bad_param
      $error("mac_seq: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GAP,
      S_EXEC,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [addr_bw-1:0] w_base_r, x_base_r, x_len_r;
   logic [addr_bw-1:0] j_cnt, res_cnt, last_addr;
   logic [kw-1:0]      k_cnt;
   logic [7:0]         gap_cnt;
   logic [1:0]         inst_r;

   logic               load_rd, exec_rd, rd_any;
   logic [addr_bw-1:0] rd_addr;
   logic               res_en, res_full;

   // Read issue and result bookkeeping.
   always_comb begin
      load_rd = 1'b0;
      exec_rd = 1'b0;
      rd_addr = '0;
      res_en  = 1'b0;
      res_full = 1'b0;

      load_rd = (state == S_LOAD) && !hold;
      exec_rd = (state == S_EXEC) && !hold;
      rd_any  = load_rd || exec_rd;
      // Address sums wrap naturally at addr_bw bits.
      rd_addr = load_rd ? (w_base_r + addr_bw'(k_cnt)) : (x_base_r + j_cnt);

      // Counter saturates at x_len so surplus pulses cannot push it past the target.
      res_en   = ((state == S_EXEC) || (state == S_DRAIN)) && valid_last && (res_cnt != x_len_r);
      // Looks ahead by one pulse so done follows the final valid_last by exactly one cycle.
      res_full = (res_cnt == x_len_r) || (res_en && ((res_cnt + addr_bw'(1)) == x_len_r));
   end

   // Next-state logic and outputs.
   always_comb begin
      state_nxt = state;
      mem_cen   = 1'b1;
      mem_addr  = last_addr;
      inst_w    = inst_r;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);

      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  if (load_rd && (k_cnt == kw'(col - 1))) state_nxt = S_GAP;
         S_GAP: begin
            if (gap_cnt == 8'(gap - 1)) begin
               state_nxt = (x_len_r == '0) ? S_DONE : S_EXEC;
            end
         end
         S_EXEC:  if (exec_rd && (j_cnt == (x_len_r - addr_bw'(1)))) state_nxt = S_DRAIN;
         S_DRAIN: if (res_full) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      if (rd_any) begin
         mem_cen  = 1'b0;
         mem_addr = rd_addr;
      end

      // Outputs read as idle for the whole reset cycle, not only after the edge.
      if (reset) begin
         mem_cen  = 1'b1;
         mem_addr = '0;
         inst_w   = 2'b00;
         busy     = 1'b0;
         done     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_base_r  <= '0;
         x_base_r  <= '0;
         x_len_r   <= '0;
         k_cnt     <= '0;
         j_cnt     <= '0;
         gap_cnt   <= '0;
         res_cnt   <= '0;
         last_addr <= '0;
         inst_r    <= 2'b00;
      end else begin
         // Data appears one cycle after the read, so the instruction is delayed to match.
         inst_r <= {exec_rd, load_rd};

         if (rd_any) last_addr <= rd_addr;

         case (state)
            S_IDLE: begin
               if (start) begin
                  w_base_r <= w_base;
                  x_base_r <= x_base;
                  x_len_r  <= x_len;
                  k_cnt    <= '0;
                  j_cnt    <= '0;
                  gap_cnt  <= '0;
                  res_cnt  <= '0;
               end
            end
            S_LOAD: if (load_rd) k_cnt <= k_cnt + kw'(1);
            S_GAP:  gap_cnt <= gap_cnt + 8'd1;
            S_EXEC: if (exec_rd) j_cnt <= j_cnt + addr_bw'(1);
            default: ;
         endcase

         if (res_en) res_cnt <= res_cnt + addr_bw'(1);
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
module tb_mac_seq;
   localparam int COL = 8;
   localparam int GAP = 8;
   localparam int AW  = 11;
   localparam int N   = 300;

   logic          clk = 1'b0;
   logic          reset, start, hold, valid_last;
   logic [AW-1:0] w_base, x_base, x_len;
   logic          mem_cen;
   logic [AW-1:0] mem_addr;
   logic [1:0]    inst_w;
   logic          busy, done;

   mac_seq #(.bw(4), .col(COL), .addr_bw(AW), .gap(GAP)) dut (
      .clk(clk), .reset(reset), .start(start), .hold(hold),
      .w_base(w_base), .x_base(x_base), .x_len(x_len), .valid_last(valid_last),
      .mem_cen(mem_cen), .mem_addr(mem_addr), .inst_w(inst_w),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int            c;
      logic [AW-1:0] addr;
      logic [1:0]    kind;
   } rd_t;

   rd_t rd_q[$];
   int  done_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic miss(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got 0x%0h want nothing (cycle %0d)", name, act, cyc);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_mem_cen"}, 32'(mem_cen), 32'd1);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_inst_w"}, 32'(inst_w), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Monitor: pops expected reads/done events whenever the DUT presents them.
   logic [1:0]    exp_inst = 2'b00;
   logic [AW-1:0] exp_park = '0;
   rd_t           mon_e;

   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         exp_inst = 2'b00;
         exp_park = '0;
      end else begin
         chk("inst_w", 32'(inst_w), 32'(exp_inst));
         exp_inst = 2'b00;
         if (mem_cen === 1'b0) begin
            if (rd_q.size() == 0) begin
               miss("unexpected_read", 32'(mem_addr));
            end else begin
               mon_e = rd_q.pop_front();
               chk("rd_cycle", 32'(cyc), 32'(mon_e.c));
               chk("rd_addr", 32'(mem_addr), 32'(mon_e.addr));
               exp_inst = mon_e.kind;
               exp_park = mon_e.addr;
            end
         end else begin
            chk("parked_addr", 32'(mem_addr), 32'(exp_park));
         end
         if (done === 1'b1) begin
            if (done_q.size() == 0) begin
               miss("unexpected_done", 32'(cyc));
            end else begin
               chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
               chk("done_busy", 32'(busy), 32'd1);
            end
         end
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         start      = 1'b0;
         hold       = 1'($urandom_range(0, 1));
         valid_last = 1'($urandom_range(0, 1));
      end
   endtask

   // hmode: 0 no hold, 1 random hold, 2 fixed stalls at LOAD k=3 and EXEC j=1.
   // abort_j >= 0: reset is asserted in the cycle that would read EXEC index abort_j.
   task automatic run_seq(input logic [AW-1:0] wb, input logic [AW-1:0] xb,
                          input logic [AW-1:0] xl, input int hmode, input int abort_j);
      bit  hold_a[N];
      bit  vl_a[N];
      int  t, s, exec_t, last_t, p, cnt, done_t, abort_t, end_t;
      rd_t e;

      for (int i = 0; i < N; i++) begin
         hold_a[i] = (hmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         vl_a[i]   = ($urandom_range(0, 9) < 4);
         if (i >= 250) begin
            hold_a[i] = 1'b0;
            vl_a[i]   = 1'b1;
         end
      end
      if (hmode == 2) begin
         hold_a[3] = 1'b1; hold_a[4] = 1'b1; hold_a[5] = 1'b1;
         hold_a[20] = 1'b1; hold_a[21] = 1'b1;
      end

      @(posedge clk); #1;
      start      = 1'b1;
      w_base     = wb;
      x_base     = xb;
      x_len      = xl;
      hold       = 1'($urandom_range(0, 1));
      valid_last = 1'($urandom_range(0, 1));
      s = cyc + 1;

      // Reference: weight reads on non-held cycles, fixed idle gap, activation reads,
      // then completion once both the last read and the x_len-th counted result are in.
      t = 0;
      abort_t = -1;
      done_t  = -1;
      for (int k = 0; k < COL; k++) begin
         while (hold_a[t]) t++;
         e.c = s + t; e.addr = wb + AW'(k); e.kind = 2'b01;
         rd_q.push_back(e);
         t++;
      end
      t += GAP;
      if (xl == '0) begin
         done_t = t;
      end else begin
         exec_t = t;
         for (int j = 0; j < int'(xl); j++) begin
            while (hold_a[t]) t++;
            if (j == abort_j) begin
               abort_t = t;
               break;
            end
            e.c = s + t; e.addr = xb + AW'(j); e.kind = 2'b10;
            rd_q.push_back(e);
            t++;
         end
         if (abort_t < 0) begin
            last_t = t - 1;
            cnt = 0;
            p = -1;
            for (int u = exec_t; u < N && p < 0; u++) begin
               if (vl_a[u]) begin
                  cnt++;
                  if (cnt == int'(xl)) p = u;
               end
            end
            done_t = (last_t + 2 > p + 1) ? last_t + 2 : p + 1;
         end
      end
      if (done_t >= 0) done_q.push_back(s + done_t);
      end_t = (abort_t >= 0) ? abort_t : done_t;

      for (int tt = 0; tt <= end_t; tt++) begin
         @(posedge clk); #1;
         start      = ($urandom_range(0, 3) == 0);
         hold       = hold_a[tt];
         valid_last = vl_a[tt];
         w_base     = AW'($urandom);
         x_base     = AW'($urandom);
         x_len      = AW'($urandom);
         if (tt == abort_t) begin
            reset = 1'b1;
            start = 1'b1;
            hold  = 1'b1;
         end
      end

      if (abort_t >= 0) begin
         @(negedge clk);
         chk_idle_outputs("abort_in_reset");
         @(posedge clk); #1;
         reset      = 1'b0;
         start      = 1'b0;
         hold       = 1'b0;
         valid_last = 1'b1;
         @(negedge clk);
         chk_idle_outputs("abort_after");
      end else begin
         @(posedge clk); #1;
         start      = 1'b0;
         hold       = 1'($urandom_range(0, 1));
         valid_last = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("end_busy", 32'(busy), 32'd0);
         chk("end_done", 32'(done), 32'd0);
      end
      chk("reads_left", 32'(rd_q.size()), 32'd0);
      chk("done_left", 32'(done_q.size()), 32'd0);
      rd_q.delete();
      done_q.delete();
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; hold = 1'b1; valid_last = 1'b0;
      w_base = '0; x_base = '0; x_len = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("in_reset");
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; hold = 1'b0;
      @(negedge clk);
      chk_idle_outputs("after_reset");
      idle_cycles(3);

      run_seq(11'h010, 11'h100, 11'd4, 0, -1);
      idle_cycles(2);
      run_seq(11'h020, 11'h200, 11'd0, 0, -1);
      idle_cycles(1);
      run_seq(11'h030, 11'h300, 11'd5, 2, -1);
      run_seq(11'h7FC, 11'h7FE, 11'd4, 0, -1);
      run_seq(11'h040, 11'h400, 11'd5, 0, 2);
      run_seq(11'h050, 11'h500, 11'd3, 0, -1);
      for (int r = 0; r < 20; r++) begin
         idle_cycles($urandom_range(0, 3));
         run_seq(AW'($urandom), AW'($urandom), AW'($urandom_range(0, 12)), 1, -1);
      end
      idle_cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter bw, default 4: activation/weight width, matching the mac row datapath.
REQ-002 Parameter col, default 8: number of MAC tiles in the driven row.
REQ-003 Parameter addr_bw, default 11: SRAM address width.
REQ-004 Parameter gap, default 8: idle cycles between kernel load and execute; legal range 1..255.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  launch request; sampled only in IDLE.
REQ-008 hold  input  1  stall; freezes read issue in LOAD/EXEC.
REQ-009 w_base  input  addr_bw  first weight address; captured on accepted start.
REQ-010 x_base  input  addr_bw  first activation address; captured on accepted start.
REQ-011 x_len  input  addr_bw  number of activation vectors; captured on accepted start.
REQ-012 valid_last  input  1  valid of the last row column, i.e. one result per pulse.
REQ-013 mem_cen  output  1  SRAM chip enable, active-low.
REQ-014 mem_addr  output  addr_bw  SRAM read address.
REQ-015 inst_w  output  2  row instruction: bit1 execute, bit0 kernel loading.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle completion pulse.

Function
REQ-018 FSM states IDLE, LOAD, GAP, EXEC, DRAIN, DONE; encoding is an implementation choice.
REQ-019 IDLE: start=1 at an edge -> LOAD at that edge, capturing w_base, x_base, x_len and clearing all counters; start while busy is ignored.
REQ-020 LOAD: each non-hold cycle drives mem_cen=0, mem_addr=w_base+k, k=0..col-1, then k increments; after the read with k=col-1 -> GAP.
REQ-021 GAP: mem_cen=1 for exactly gap cycles, then -> EXEC, or -> DONE if captured x_len=0.
REQ-022 EXEC: each non-hold cycle drives mem_cen=0, mem_addr=x_base+j, j=0..x_len-1; after the read with j=x_len-1 -> DRAIN.
REQ-023 Address sums wrap modulo 2^addr_bw.
REQ-024 hold=1 in LOAD/EXEC: mem_cen=1, counter frozen, state unchanged; hold is ignored in all other states.
REQ-025 SRAM read latency is one cycle: inst_w is registered so that inst_w=01 exactly one cycle after each LOAD read and inst_w=10 exactly one cycle after each EXEC read; otherwise inst_w=00.
REQ-026 inst_w=11 never occurs.
REQ-027 A result counter counts valid_last pulses in EXEC and DRAIN; pulses in any other state are ignored.
REQ-028 DRAIN: -> DONE in the cycle after the result counter reaches x_len, including when the count completed during EXEC.
REQ-029 DONE lasts one cycle with done=1, then -> IDLE; start in DONE is ignored.
REQ-030 mem_addr holds its last value when mem_cen=1.
REQ-031 Latency with no hold: first mem_cen=0 in the cycle after start is accepted; the first inst_w=10 is col+gap+1 cycles after the first LOAD read.

Reset
REQ-032 reset=1 at an edge forces IDLE from any state, including mid-LOAD/EXEC/DRAIN; it clears all counters and captured registers.
REQ-033 Output values while in reset and immediately after: mem_cen=1, mem_addr=0, inst_w=00, busy=0, done=0.
REQ-034 Reset has priority over start and hold in the same cycle.

Verification
REQ-035 col=8, gap=8, w_base=0x010, x_base=0x100, x_len=4, no hold -> mem_addr 0x010..0x017 then 0x100..0x103; inst_w=01 for 8 cycles, 00 for 8 cycles, then 10 for 4 cycles; done one cycle after the 4th valid_last.
REQ-036 x_len=0 -> 8 LOAD reads, gap idle cycles, no EXEC reads, inst_w never 10, done immediately after GAP.
REQ-037 hold=1 for 3 cycles at LOAD k=3 and for 2 cycles at EXEC j=1 -> no skipped or duplicated addresses; inst_w=00 gaps of 3 and 2 cycles; totals 8 and x_len.
REQ-038 x_base=0x7FE, x_len=4, addr_bw=11 -> EXEC addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-039 reset asserted mid-EXEC at j=2 -> next cycle IDLE, mem_cen=1, inst_w=00, busy=0, no done; a following start runs a full clean sequence.
REQ-040 start pulses during busy, and valid_last pulses in IDLE/LOAD -> ignored; the result count and done timing are unchanged.
